hls_run_monitor: RTL

Synthesizable run controller placed directly upstream of a Bambu-generated top accelerator (`main`), replacing the file-driven simulation harness for on-board runs. It resets the accelerator and issues start pulses on host command. It measures cycles to `done_port`, captures `return_port`, compares it against a host-supplied expected value and reports pass/fail/timeout through a valid/ready result channel.

---
 rtl/hls_run_monitor.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/hls_run_monitor.sv
// Run controller for a Bambu "main" accelerator: resets it, issues start,
// times the run to done_port and reports pass/fail/unchecked/timeout.
module hls_run_monitor #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 200000000,
  parameter int STAT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_check,
  input  logic [DATA_W-1:0] cmd_expected,
  output logic              acc_reset,
  output logic              acc_clock_gating,
  output logic              acc_start,
  input  logic              acc_done,
  input  logic [DATA_W-1:0] acc_return,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_status,
  output logic [DATA_W-1:0] res_value,
  output logic [CNT_W-1:0]  res_cycles,
  output logic [STAT_W-1:0] pass_cnt,
  output logic [STAT_W-1:0] fail_cnt,
  output logic              err_spurious
);

  typedef enum logic [2:0] {
    ARST, IDLE, START, WAIT, RECOVER, REPORT
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [1:0] ST_FAIL = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_NCHK = 2'd2;
  localparam logic [1:0] ST_TMO  = 2'd3;

  state_t            state;
  logic              phase;
  logic              chk_q;
  logic [DATA_W-1:0] exp_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              is_fail;

  assign cnt_nxt          = cnt + CNT_W'(1);
  assign cmd_ready        = (state == IDLE);
  assign acc_clock_gating = 1'b0;
  assign is_fail          = (res_status == ST_FAIL) ||
                            (res_status == ST_TMO);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ARST;
      phase        <= 1'b0;
      chk_q        <= 1'b0;
      exp_q        <= '0;
      cnt          <= '0;
      acc_reset    <= 1'b0;
      acc_start    <= 1'b0;
      res_valid    <= 1'b0;
      res_status   <= ST_FAIL;
      res_value    <= '0;
      res_cycles   <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (acc_done && state != WAIT)
        err_spurious <= 1'b1;
      case (state)
        ARST: begin
          // two cycles of accelerator reset, phase marks the second
          if (phase) begin
            phase     <= 1'b0;
            acc_reset <= 1'b1;
            state     <= IDLE;
          end else begin
            phase <= 1'b1;
          end
        end
        IDLE: begin
          if (cmd_valid) begin
            chk_q     <= cmd_check;
            exp_q     <= cmd_expected;
            cnt       <= '0;
            acc_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          acc_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_nxt;
          if (acc_done) begin
            res_value  <= acc_return;
            res_cycles <= cnt_nxt;
            if (!chk_q)
              res_status <= ST_NCHK;
            else if (acc_return == exp_q)
              res_status <= ST_PASS;
            else
              res_status <= ST_FAIL;
            res_valid <= 1'b1;
            state     <= REPORT;
          end else if (cnt_nxt == TMO) begin
            res_status <= ST_TMO;
            res_value  <= '0;
            res_cycles <= TMO;
            acc_reset  <= 1'b0;
            phase      <= 1'b0;
            state      <= RECOVER;
          end
        end
        RECOVER: begin
          if (phase) begin
            phase     <= 1'b0;
            acc_reset <= 1'b1;
            res_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            phase <= 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
            if (res_status == ST_PASS) begin
              if (pass_cnt != {STAT_W{1'b1}})
                pass_cnt <= pass_cnt + STAT_W'(1);
            end else if (is_fail) begin
              if (fail_cnt != {STAT_W{1'b1}})
                fail_cnt <= fail_cnt + STAT_W'(1);
            end
          end
        end
        default: begin
          state     <= ARST;
          acc_reset <= 1'b0;
          phase     <= 1'b0;
        end
      endcase
    end
  end

endmodule
